fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameters: none; widths fixed (8-bit PC, 32-bit instruction).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_addr  output  8  instruction memory address; equals fetch_pc combinationally.
REQ-005 imem_data  input  32  instruction memory read data; valid in the same cycle as imem_addr (combinational memory).
REQ-006 redirect_valid  input  1  request to discard buffered instructions and restart fetch.
REQ-007 redirect_pc  input  8  restart address, sampled when redirect_valid=1.
REQ-008 out_valid  output  1  head entry available to decode.
REQ-009 out_ready  input  1  decode accepts head entry this cycle.
REQ-010 out_inst  output  32  instruction of head entry.
REQ-011 out_pc  output  8  address of head entry.
REQ-012 stall_cnt  output  16  backpressure cycle count; present only with FETCH_PERF_CNT_EN.

Function
REQ-013 State: fetch_pc (8 bits), 2-entry FIFO of {pc[7:0], inst[31:0]}, occupancy count 0..2.
REQ-014 fire = out_valid & out_ready; a fire pops the head entry at the rising edge.
REQ-015 push = !redirect_valid & (count<2 | fire); a push writes {fetch_pc, imem_data} to the tail at the rising edge.
REQ-016 On push, fetch_pc increments by 1 modulo 256 (8'hFF wraps to 8'h00); without push, fetch_pc holds.
REQ-017 Push and pop in the same cycle leave count unchanged; FIFO order is strictly preserved.
REQ-018 out_valid = (count!=0), combinational from registered state; no combinational path from out_ready to out_valid.
REQ-019 When count==0, out_inst = 32'h0 and out_pc = 8'h0; otherwise they show the head entry.
REQ-020 Redirect has priority over push and fire: at the edge, count <= 0, fetch_pc <= redirect_pc, no push; head is dropped even if out_ready=1 (decode must ignore same-cycle fire).
REQ-021 Latency: address presented in cycle N appears on out_inst with out_valid=1 in cycle N+1 when FIFO was empty.
REQ-022 Full (count==2) with out_ready=0: no push, fetch_pc holds, outputs stable until fire or redirect.
REQ-023 Sustained out_ready=1 yields one instruction per cycle with consecutive out_pc values.

Reset
REQ-024 rst=1 asynchronously forces fetch_pc=0, count=0, FIFO storage=0, stall_cnt=0; hence out_valid=0, out_inst=0, out_pc=0, imem_addr=0.
REQ-025 First push occurs at the first rising edge with rst=0; reset asserted mid-operation discards all buffered entries immediately.

Configuration
REQ-026 Macro FETCH_PERF_CNT_EN defined: stall_cnt port exists; increments by 1 on each edge where out_valid=1 and out_ready=0; saturates at 16'hFFFF; unaffected by redirect.
REQ-027 Macro FETCH_PERF_CNT_EN undefined: stall_cnt port and counter logic absent; all other behaviour identical.

Verification
REQ-028 Reset release, out_ready=1, memory word at addr k = 32'h1000_0000+k -> out_valid from cycle 1, out_pc 0,1,2,3 with out_inst 32'h1000_0000..32'h1000_0003 consecutive.
REQ-029 out_ready=0 for 5 cycles after reset -> count reaches 2, imem_addr holds 8'h02, out_pc stays 0; raise out_ready -> out_pc 0,1,2,3 with no gap or duplicate.
REQ-030 redirect_valid=1, redirect_pc=8'h40 while count==2 and out_ready=1 -> next cycle out_valid=0, imem_addr=8'h40; following cycle out_pc=8'h40.
REQ-031 Redirect to 8'hFE, out_ready=1 -> out_pc sequence 8'hFE, 8'hFF, 8'h00, 8'h01.
REQ-032 Assert rst asynchronously between edges with count==2 -> out_valid, out_pc, imem_addr drop to 0 before next edge.
REQ-033 FETCH_PERF_CNT_EN defined, out_ready=0 for 10 cycles after first valid -> stall_cnt=10; force 70000 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives an 8-bit fetch PC to a combinational instruction
// memory and buffers fetched words in a 2-entry FIFO toward decode.
// A redirect flushes the FIFO and restarts fetch at the supplied address.
// Optional build macro FETCH_PERF_CNT_EN adds a saturating 16-bit backpressure
// counter (stall_cnt port); without it the port and logic are absent.
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [7:0]  out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  // Architectural state
  logic [7:0]  r_fetch_pc;
  logic [7:0]  r_ent_pc   [2];
  logic [31:0] r_ent_inst [2];
  logic        r_head;
  logic [1:0]  r_count;

  // Handshake and FIFO control
  logic        w_fire;
  logic        w_push;
  logic        w_pop;
  logic        w_tail;
  logic [1:0]  w_count_nxt;
  logic        w_head_nxt;
  logic [7:0]  w_fetch_pc_nxt;

  // Decode the handshake and derive push/pop; redirect suppresses both.
  always_comb begin
    w_fire = out_valid & out_ready;
    w_push = ~redirect_valid & ((r_count != 2'd2) | w_fire);
    w_pop  = w_fire & ~redirect_valid;
    // Tail slot: with two entries and a pop, the freed head slot is the tail.
    w_tail = r_head ^ r_count[0];
  end

  // Next-state for occupancy, head pointer and fetch PC.
  always_comb begin
    w_count_nxt    = r_count;
    w_head_nxt     = r_head;
    w_fetch_pc_nxt = r_fetch_pc;
    if (redirect_valid) begin
      w_count_nxt    = 2'd0;
      w_head_nxt     = 1'b0;
      w_fetch_pc_nxt = redirect_pc;
    end else begin
      if (w_pop) begin
        w_head_nxt = ~r_head;
      end
      if (w_push) begin
        w_fetch_pc_nxt = r_fetch_pc + 8'd1;
      end
      unique case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 2'd1;
        2'b01:   w_count_nxt = r_count - 2'd1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= 8'h00;
      r_head     <= 1'b0;
      r_count    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_ent_pc[i]   <= 8'h00;
        r_ent_inst[i] <= 32'h0;
      end
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_head     <= w_head_nxt;
      r_count    <= w_count_nxt;
      if (w_push) begin
        r_ent_pc[w_tail]   <= r_fetch_pc;
        r_ent_inst[w_tail] <= imem_data;
      end
    end
  end

  // Outputs depend only on registered state; empty FIFO shows zeros.
  always_comb begin
    imem_addr = r_fetch_pc;
    out_valid = (r_count != 2'd0);
    out_pc    = 8'h00;
    out_inst  = 32'h0;
    if (out_valid) begin
      out_pc   = r_ent_pc[r_head];
      out_inst = r_ent_inst[r_head];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_stall_cnt;

  // Count cycles where decode holds off a valid head; saturates, ignores redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'h0000;
    end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  // Performance counter not built.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [7:0]  out_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif

  fetch_stage u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  // Combinational instruction memory: word at address k is 0x1000_0000 + k.
  assign imem_data = 32'h1000_0000 + {24'h0, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] inst;
  } ent_t;

  ent_t       sb[$];
  logic [7:0] fired[$];
  logic [7:0] m_pc;
  int         n_tests;
  int         n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare DUT outputs against the scoreboard head and model fetch PC.
  task automatic check_state();
    chk("out_valid", {31'h0, out_valid}, {31'h0, sb.size() != 0});
    chk("imem_addr", {24'h0, imem_addr}, {24'h0, m_pc});
    if (sb.size() == 0) begin
      chk("empty_pc", {24'h0, out_pc}, 32'h0);
      chk("empty_inst", out_inst, 32'h0);
    end else begin
      chk("head_pc", {24'h0, out_pc}, {24'h0, sb[0].pc});
      chk("head_inst", out_inst, sb[0].inst);
    end
  endtask

  // One clock: drive inputs at the negedge, update the model, check at next negedge.
  task automatic cycle(input logic rdy, input logic rv, input logic [7:0] rpc);
    ent_t exp;
    bit   fire;
    bit   room;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    fire = (sb.size() != 0) && rdy;
    room = sb.size() < 2;
    if (rv) begin
      sb.delete();
      m_pc = rpc;
    end else begin
      if (fire) begin
        exp = sb.pop_front();
        chk("fire_pc", {24'h0, out_pc}, {24'h0, exp.pc});
        chk("fire_inst", out_inst, exp.inst);
        fired.push_back(out_pc);
      end
      if (room || fire) begin
        sb.push_back({m_pc, 32'h1000_0000 + {24'h0, m_pc}});
        m_pc = m_pc + 8'd1;
      end
    end
    @(negedge clk);
    check_state();
  endtask

  // Assert reset between edges, check the asynchronous clear, release at a negedge.
  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_pc", {24'h0, out_pc}, 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_addr", {24'h0, imem_addr}, 32'h0);
    sb.delete();
    m_pc = 8'h00;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_fired(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    logic [7:0] e [4];
    e[0] = a; e[1] = b; e[2] = c; e[3] = d;
    chk({tag, "_n"}, {31'h0, fired.size() >= 4}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      if (i < fired.size()) chk(tag, {24'h0, fired[i]}, {24'h0, e[i]});
    end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    m_pc           = 8'h00;
    @(negedge clk);
    apply_reset();
    check_state();

    // Streaming with out_ready held high.
    fired.delete();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'h00);
    chk_fired("stream", 8'h00, 8'h01, 8'h02, 8'h03);

    // Backpressure after reset, then drain.
    apply_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00);
    chk("bp_addr", {24'h0, imem_addr}, 32'h02);
    chk("bp_pc", {24'h0, out_pc}, 32'h00);
    chk("bp_valid", {31'h0, out_valid}, 32'h1);
    fired.delete();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00);
    chk_fired("drain", 8'h00, 8'h01, 8'h02, 8'h03);

    // Redirect while full with out_ready high.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00);
    chk("full_valid", {31'h0, out_valid}, 32'h1);
    cycle(1'b1, 1'b1, 8'h40);
    chk("redir_valid", {31'h0, out_valid}, 32'h0);
    chk("redir_addr", {24'h0, imem_addr}, 32'h40);
    cycle(1'b1, 1'b0, 8'h00);
    chk("redir_pc", {24'h0, out_pc}, 32'h40);

    // PC wrap after redirect near the top of the address space.
    cycle(1'b1, 1'b1, 8'hFE);
    fired.delete();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00);
    chk_fired("wrap", 8'hFE, 8'hFF, 8'h00, 8'h01);

    // Mixed ready pattern.
    for (int i = 0; i < 20; i++) cycle(1'($urandom_range(0, 1)), 1'b0, 8'h00);

    // Asynchronous reset with a full FIFO.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00);
    chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    apply_reset();
    check_state();

`ifdef FETCH_PERF_CNT_EN
    chk("stall_rst", {16'h0, stall_cnt}, 32'h0);
    cycle(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'h00);
    chk("stall_10", {16'h0, stall_cnt}, 32'd10);
    repeat (70000) @(negedge clk);
    chk("stall_sat", {16'h0, stall_cnt}, 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
